// File: rtl/shared_counter_sched.sv
// shared_counter_sched
// Round-robin scheduler that time-shares one down-counting interval timer
// between two requesters. The winner's length is loaded into the counter,
// the counter runs down to zero (or is aborted), and a one-cycle done pulse
// is returned to the requester that owned the interval.
module shared_counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_len,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_len,
    output logic             req1_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             owner,
    output logic             done0,
    output logic             done1,
    output logic             aborted
);

    // Scheduler states. DONE is a single-cycle state that carries the pulse.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [1:0] state;
    // Index of the requester granted most recently; the other one wins a tie.
    logic       rr_last;

    assign busy = (state != IDLE);

    // Grant decision: only in IDLE, never during reset, tie broken by rr_last.
    always_comb begin
        // NOTE: both outputs get a default before any branch, otherwise the
        // paths that do not assign them would infer latches.
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                if (rr_last) begin
                    req0_ready = 1'b1;
                end else begin
                    req1_ready = 1'b1;
                end
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    // State, counter and result registers; reset kills any interval silently.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            count   <= ZERO;
            owner   <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            // Done pulses last exactly one cycle unless re-armed below.
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        count   <= req0_len;
                        owner   <= 1'b0;
                        rr_last <= 1'b0;
                        aborted <= 1'b0;
                        state   <= RUN;
                    end else if (req1_ready) begin
                        count   <= req1_len;
                        owner   <= 1'b1;
                        rr_last <= 1'b1;
                        aborted <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (count == ZERO) begin
                        // Natural completion takes priority over abort.
                        state   <= DONE;
                        aborted <= 1'b0;
                        done0   <= ~owner;
                        done1   <= owner;
                    end else if (abort) begin
                        // Counter freezes at its current value.
                        state   <= DONE;
                        aborted <= 1'b1;
                        done0   <= ~owner;
                        done1   <= owner;
                    end else begin
                        count <= count - ONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    count   <= ZERO;
                    aborted <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    count <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_counter_sched.sv
// Directed testbench for shared_counter_sched. Inputs are driven and outputs
// sampled on the falling clock edge; "cycle n" is the n-th falling edge after
// the accept edge, so a done pulse for length L is seen in cycle L+2.
module tb_shared_counter_sched;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_len;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_len;
    logic             req1_ready;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             owner;
    logic             done0;
    logic             done1;
    logic             aborted;

    int total = 0;
    int bad   = 0;

    shared_counter_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .owner      (owner),
        .done0      (done0),
        .done1      (done1),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raise one valid, confirm it alone is ready, let it be accepted.
    task automatic issue(input int idx, input int len, input bit hold);
        if (idx == 0) begin
            req0_valid = 1'b1;
            req0_len   = len[WIDTH-1:0];
        end else begin
            req1_valid = 1'b1;
            req1_len   = len[WIDTH-1:0];
        end
        #1;
        chk($sformatf("issue%0d ready0", idx), req0_ready, idx == 0);
        chk($sformatf("issue%0d ready1", idx), req1_ready, idx == 1);
        tick();
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    // Follow a normal interval from cycle 1 through the first IDLE cycle.
    task automatic track(input int idx, input int len);
        int exp_count;
        for (int n = 1; n <= len + 3; n++) begin
            exp_count = (n - 1 <= len) ? len - (n - 1) : 0;
            chk($sformatf("L%0d c%0d count", len, n), count, exp_count);
            chk($sformatf("L%0d c%0d busy", len, n), busy, n <= len + 2);
            chk($sformatf("L%0d c%0d done0", len, n), done0, idx == 0 && n == len + 2);
            chk($sformatf("L%0d c%0d done1", len, n), done1, idx == 1 && n == len + 2);
            chk($sformatf("L%0d c%0d aborted", len, n), aborted, 0);
            chk($sformatf("L%0d c%0d owner", len, n), owner, idx);
            if (n <= len + 2) begin
                chk($sformatf("L%0d c%0d ready0", len, n), req0_ready, 0);
                chk($sformatf("L%0d c%0d ready1", len, n), req1_ready, 0);
            end
            if (n < len + 3) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_len   = 4'd3;
        req1_len   = 4'd7;
        abort      = 1'b0;

        // Reset with both requesters valid: nothing granted, all outputs 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst ready0", req0_ready, 0);
            chk("rst ready1", req1_ready, 0);
            chk("rst count", count, 0);
            chk("rst busy", busy, 0);
            chk("rst owner", owner, 0);
            chk("rst done0", done0, 0);
            chk("rst done1", done1, 0);
            chk("rst aborted", aborted, 0);
        end
        rst = 1'b0;
        #1;
        chk("post-rst ready0", req0_ready, 1);
        chk("post-rst ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        track(0, 3);

        // Single requests on each side.
        issue(0, 5, 1'b0);
        track(0, 5);
        issue(1, 4, 1'b0);
        track(1, 4);

        // Fairness: both valid continuously, grants alternate 0,1,0,1 and
        // the next grant is ready in cycle L+3 of the previous one.
        req0_len   = 4'd2;
        req1_len   = 4'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("rr g%0d ready0", g), req0_ready, (g % 2) == 0);
            chk($sformatf("rr g%0d ready1", g), req1_ready, (g % 2) == 1);
            tick();
            track(g % 2, 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Length boundaries.
        issue(0, 0, 1'b0);
        track(0, 0);
        issue(1, 15, 1'b0);
        track(1, 15);

        // Abort when count reads 6: frozen count, aborted pulse.
        issue(0, 10, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            chk($sformatf("ab c%0d count", n), count, 11 - n);
            if (n < 5) tick();
        end
        abort = 1'b1;
        tick();
        chk("ab done0", done0, 1);
        chk("ab done1", done1, 0);
        chk("ab aborted", aborted, 1);
        chk("ab count frozen", count, 6);
        chk("ab busy", busy, 1);
        abort = 1'b0;
        tick();
        chk("ab after done0", done0, 0);
        chk("ab after aborted", aborted, 0);
        chk("ab after busy", busy, 0);
        chk("ab after count", count, 0);

        // Abort coinciding with count 0: normal completion wins.
        issue(1, 2, 1'b0);
        chk("ab0 c1 count", count, 2);
        tick();
        chk("ab0 c2 count", count, 1);
        tick();
        chk("ab0 c3 count", count, 0);
        abort = 1'b1;
        tick();
        chk("ab0 done1", done1, 1);
        chk("ab0 aborted", aborted, 0);
        tick();
        chk("ab0 idle busy", busy, 0);
        chk("ab0 idle done1", done1, 0);
        // Abort held in IDLE changes nothing.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle-abort busy", busy, 0);
            chk("idle-abort count", count, 0);
            chk("idle-abort done", {done0, done1}, 0);
            chk("idle-abort aborted", aborted, 0);
        end
        abort = 1'b0;

        // Reset while requester 1 runs with count 4: silent kill.
        issue(1, 8, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            chk($sformatf("mr c%0d count", n), count, 9 - n);
            if (n < 5) tick();
        end
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_len   = 4'd6;
        #1;
        chk("mr busy", busy, 0);
        chk("mr count", count, 0);
        chk("mr owner", owner, 0);
        chk("mr ready", {req0_ready, req1_ready}, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mr no done", {done0, done1}, 0);
            chk("mr held busy", busy, 0);
        end
        rst = 1'b0;
        #1;
        chk("mr rel ready0", req0_ready, 1);
        chk("mr rel ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("mr2 c1 count", count, 6);
        chk("mr2 c1 owner", owner, 0);
        tick();
        tick();
        // Requester 0 was granted last; reset must restore rr_last to 1.
        rst = 1'b1;
        #1;
        chk("mr2 busy", busy, 0);
        tick();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mr2 rel ready0", req0_ready, 1);
        chk("mr2 rel ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        track(0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_counter_sched.md
# shared_counter_sched

Round-robin scheduler that shares a single 4-bit down-counting interval timer between two requesters. Each requester asks for a timed interval of N clock cycles. The block arbitrates, loads and runs the counter on behalf of the winner, and pulses a per-requester done when the interval ends. It sits between client logic and the 4-bit counter resource, so clients never drive the counter directly.

## Interface
- `WIDTH`, default 4: counter and length width.
- `clk` in, 1 bit: rising-edge clock.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `req0_valid` in, 1 bit: requester 0 has a pending interval request.
- `req0_len` in, WIDTH bits: interval length for requester 0, sampled at accept.
- `req0_ready` out, 1 bit: requester 0 accepted this cycle (combinational).
- `req1_valid`, `req1_len`, `req1_ready`: same as the requester 0 ports, for requester 1.
- `abort` in, 1 bit: terminate the running interval early.
- `count` out, WIDTH bits: current counter value.
- `busy` out, 1 bit: high while the state is not IDLE.
- `owner` out, 1 bit: index of the current or last granted requester.
- `done0` out, 1 bit: one-cycle end-of-interval pulse for requester 0.
- `done1` out, 1 bit: one-cycle end-of-interval pulse for requester 1.
- `aborted` out, 1 bit: high with done when the interval ended by abort.

## Operation
- Transfer on the rising edge where `reqN_valid && reqN_ready`.
- Once `reqN_valid` is high, the requester holds it and `reqN_len` stable until ready is seen.
- Internal round-robin pointer `rr_last` holds the index last granted; its reset value is 1, so requester 0 wins first.
- States:
  - **IDLE**
    - Ready logic, combinational, only in IDLE and never while `rst` is high:
      - Only one valid: that requester gets ready.
      - Both valid: ready goes to `~rr_last`.
    - On accept: `count <= reqN_len`, `owner <= N`, `rr_last <= N`, go to RUN.
  - **RUN**
    - If `count == 0`: go to DONE with `aborted <= 0`. Normal completion wins over a simultaneous `abort`.
    - Else if `abort`: go to DONE with `aborted <= 1`; `count` holds its value.
    - Else: `count <= count - 1`.
  - **DONE**
    - Assert `done[owner]` for exactly one cycle.
    - `aborted` is valid this cycle.
    - Next edge: go to IDLE and set `count <= 0`.
- `abort` is ignored in IDLE and DONE.
- Length 0 is legal: one RUN cycle, then DONE.
- Length arithmetic is unsigned WIDTH-bit, so the maximum length is 15. The decrement never wraps, because 0 exits RUN.
- All `reqN_ready` are 0 in RUN and DONE. Requests arriving there wait.
- Asserting `rst` mid-operation:
  - Immediately returns to IDLE and clears `count`, `owner` and `aborted`.
  - Sets `rr_last = 1`.
  - No done pulse is issued for the killed interval.

## Timing
- Reset values:
  - `count` = 0, `busy` = 0, `owner` = 0.
  - `done0` = 0, `done1` = 0, `aborted` = 0.
  - `req0_ready` = 0, `req1_ready` = 0.
- `count`, `owner`, `done*` and `aborted` are registered. `busy` decodes from the state register. Ready is combinational from state, valid and `rr_last`.
- Label the accept edge E0.
  - `count` = L after E0, then decrements by 1 per edge, reaching 0 after edge E0+L.
  - DONE is entered at edge E0+L+1, so `doneN` is high in the cycle after E0+L+1.
  - IDLE is re-entered at E0+L+2.
- Earliest next accept is edge E0+L+3. Per-grant occupancy is L+3 cycles.
- Abort sampled at edge Ek (Ek < E0+L+1, `count` != 0): DONE entered at Ek, done pulse in the following cycle.
- `busy` rises after E0 and falls after E0+L+2.

## Test plan
- **Reset values:** hold `rst` for 3 cycles with both valids high. Required: all outputs 0 and no ready during reset. After release, requester 0 is granted first.
- **Single request:** req0 alone with len=5.
  - `count` reads 5,4,3,2,1,0 on consecutive cycles.
  - `done0` pulses once, 7 cycles after the accept edge (E0+L+2 with L=5).
  - `aborted` = 0 and `done1` never asserts.
- **Fairness:** both valid continuously with len=2.
  - Grants alternate 0,1,0,1.
  - `owner` matches each done.
  - Each grant occupies 5 cycles.
- **Length 0 and maximum:** len=0 gives done 2 cycles after accept with `count` staying 0. len=15 gives 15 decrements and done 17 cycles after accept.
- **Abort:** len=10, then `abort` when `count`=6.
  - `count` freezes at 6.
  - done pulses with `aborted` = 1.
  - `abort` at `count`=0 gives `aborted` = 0.
  - `abort` in IDLE has no effect.
- **Reset mid-run:** assert `rst` while `count`=4 for requester 1.
  - State returns to IDLE immediately, with no `done1` pulse.
  - After release, with both requesters valid, requester 0 wins.
